pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences bring-up of the iCE40 PLL (12 MHz ref -> 48 MHz core) and the core's reset.
//  Runs on the always-on reference clock. Drives PLL RESETB, qualifies the async PLL lock
//  output, and holds the 48 MHz domain in reset until lock has been stable.
//  Monitors lock during operation; on loss, re-resets the PLL and the core. Retries a
//  failed lock a bounded number of times, then reports failure.
// PARAMETERS
//  RST_CYCLES      16    cycles RESETB is held low per PLL reset attempt (>=1)
//  LOCK_STABLE     64    consecutive synced-lock-high cycles required to accept lock (>=1)
//  LOCK_TIMEOUT    4096  max cycles in WAIT_LOCK per attempt before a retry (>LOCK_STABLE)
//  RELEASE_CYCLES  32    cycles sys_reset stays high after lock is accepted (>=1)
//  MAX_RETRIES     3     retries after the first attempt before FAIL (0..15)
// PORTS
//  clock_in         in   1  12 MHz reference clock, also the PLL reference
//  reset            in   1  synchronous, active-high
//  pll_locked       in   1  PLL LOCK output; asynchronous to clock_in
//  restart          in   1  1-cycle pulse: restart the full sequence from PLL_RST
//  pll_resetb       out  1  to PLL RESETB; 0 = PLL held in reset
//  sys_reset        out  1  core reset, active-high; core side resynchronises it
//  ready            out  1  1 only in RUN
//  fail             out  1  1 only in FAIL
//  lock_lost_count  out  8  saturating count of lock losses seen in RUN
//  state_o          out  3  PLL_RST=0 WAIT_LOCK=1 RELEASE=2 RUN=3 FAIL=4
// BEHAVIOUR
//  - All outputs are registered. Reset values: pll_resetb=0, sys_reset=1, ready=0, fail=0,
//    lock_lost_count=0, state_o=0. Internal counters and retry count are 0.
//  - pll_locked passes through a 2-FF synchroniser to give locked_s (2-cycle latency).
//    Only locked_s is used.
//  - reset is checked first and overrides everything. restart is checked next: from any
//    state it goes to PLL_RST and clears counters and retries. It does not clear
//    lock_lost_count.
//  - PLL_RST: pll_resetb=0, sys_reset=1. Stays exactly RST_CYCLES cycles, then WAIT_LOCK.
//  - WAIT_LOCK: pll_resetb=1, sys_reset=1.
//    - stable counter increments while locked_s=1 and clears to 0 when locked_s=0.
//    - timeout counter increments every cycle.
//    - After LOCK_STABLE consecutive locked_s=1 cycles, go to RELEASE.
//    - After LOCK_TIMEOUT cycles: if retries==MAX_RETRIES go to FAIL; otherwise retries++
//      and go to PLL_RST.
//    - If stable and timeout complete in the same cycle, success wins.
//  - RELEASE: pll_resetb=1, sys_reset=1.
//    - locked_s=0 at any point: go to PLL_RST, retries++ (FAIL if already MAX_RETRIES).
//      lock_lost_count is unchanged.
//    - After RELEASE_CYCLES cycles: go to RUN and clear retries.
//  - RUN: sys_reset=0, ready=1. locked_s=0 -> next cycle state PLL_RST, sys_reset=1,
//    ready=0, pll_resetb=0, lock_lost_count+1 (saturates at 255, no wrap).
//  - FAIL: pll_resetb=0 (PLL powered down), sys_reset=1, fail=1. Leaves only on restart
//    or reset.
//  - Counter widths come from $clog2 of the largest parameter; no counter wraps.
//  - Timing reference: cycle 0 is the first cycle after reset deasserts. With defaults and
//    pll_locked tied 1: ready first high at cycle 112 (16+64+32).
// TESTING
//  1. pll_locked tied 1 from t=0 -> pll_resetb high at cycle 16; sys_reset low and ready
//     high at cycle 112; lock_lost_count=0.
//  2. pll_locked tied 0 -> 4 attempts of 16+4096 cycles each; fail=1 and state_o=4 at
//     cycle 16448; pll_resetb=0 afterwards.
//  3. In RUN, pull pll_locked low for 1 cycle -> within 3 cycles sys_reset=1, ready=0,
//     lock_lost_count=1; with lock restored, ready returns 112 cycles after re-entering
//     PLL_RST.
//  4. Lock chatter in WAIT_LOCK (high 40 / low 2, repeating) -> never reaches RELEASE;
//     retries then FAIL as in 2. Separately, stable and timeout completing in the same
//     cycle -> RELEASE.
//  5. In FAIL, pulse restart -> next cycle state_o=0, fail=0; full sequence completes
//     with lock present.
//  6. Force 300 RUN lock losses -> lock_lost_count holds at 255. Assert reset mid-WAIT_LOCK
//     -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and core reset sequencer running on the always-on 12 MHz reference.
// Holds the PLL in reset, qualifies lock, releases the core and re-sequences on lock loss.
module pll_reset_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_STABLE    = 64,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int RELEASE_CYCLES = 32,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_lost_count,
  output logic [2:0] state_o
);

  localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ?
                           ((RST_CYCLES > RELEASE_CYCLES) ? RST_CYCLES : RELEASE_CYCLES) :
                           ((LOCK_TIMEOUT > RELEASE_CYCLES) ? LOCK_TIMEOUT : RELEASE_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RTY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] stable, stable_n;
  logic [3:0]    retries, retries_n;
  logic [7:0]    lost_n;
  logic [1:0]    sync_pipe;
  logic          locked_s;

  // Two-flop synchroniser for the asynchronous PLL lock output.
  always_ff @(posedge clock_in) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], pll_locked};
  end
  assign locked_s = sync_pipe[1];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state           <= ST_PLL_RST;
      cnt             <= '0;
      stable          <= '0;
      retries         <= '0;
      lock_lost_count <= '0;
      pll_resetb      <= 1'b0;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      stable          <= stable_n;
      retries         <= retries_n;
      lock_lost_count <= lost_n;
      pll_resetb      <= (state_n == ST_WAIT_LOCK) || (state_n == ST_RELEASE) ||
                         (state_n == ST_RUN);
      sys_reset       <= (state_n != ST_RUN);
      ready           <= (state_n == ST_RUN);
      fail            <= (state_n == ST_FAIL);
    end
  end

  assign state_o = state;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stable_n  = stable;
    retries_n = retries;
    lost_n    = lock_lost_count;
    if (restart) begin
      state_n   = ST_PLL_RST;
      cnt_n     = '0;
      stable_n  = '0;
      retries_n = '0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_n  = ST_WAIT_LOCK;
            cnt_n    = '0;
            stable_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          cnt_n    = cnt + 1'b1;
          stable_n = locked_s ? stable + 1'b1 : '0;
          // Stable-lock completion takes priority over a coincident timeout.
          if (locked_s && stable == STB_LAST) begin
            state_n  = ST_RELEASE;
            cnt_n    = '0;
            stable_n = '0;
          end else if (cnt == TMO_LAST) begin
            cnt_n    = '0;
            stable_n = '0;
            if (retries == RTY_MAX) begin
              state_n = ST_FAIL;
            end else begin
              state_n   = ST_PLL_RST;
              retries_n = retries + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (!locked_s) begin
            cnt_n = '0;
            if (retries == RTY_MAX) begin
              state_n = ST_FAIL;
            end else begin
              state_n   = ST_PLL_RST;
              retries_n = retries + 1'b1;
            end
          end else if (cnt == REL_LAST) begin
            state_n   = ST_RUN;
            cnt_n     = '0;
            retries_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_n = ST_PLL_RST;
            cnt_n   = '0;
            if (lock_lost_count != 8'hFF) lost_n = lock_lost_count + 1'b1;
          end
        end
        ST_FAIL: begin
          state_n = ST_FAIL;
        end
        default: begin
          state_n = ST_PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with default parameters and hand-computed cycle counts.
// Cycle 0 is the interval after the last clock edge that sampled reset high.
module tb_pll_reset_sequencer;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb, sys_reset, ready, fail;
  logic [7:0] lock_lost_count;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;

  pll_reset_sequencer dut (
    .clock_in        (clock_in),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_resetb      (pll_resetb),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .fail            (fail),
    .lock_lost_count (lock_lost_count),
    .state_o         (state_o)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},      32'(state_o), 0);
    chk({tag, " pll_resetb"}, 32'(pll_resetb), 0);
    chk({tag, " sys_reset"},  32'(sys_reset), 1);
    chk({tag, " ready"},      32'(ready), 0);
    chk({tag, " fail"},       32'(fail), 0);
    chk({tag, " lost"},       32'(lock_lost_count), 0);
  endtask

  // One RUN lock-loss pulse from a RUN cycle q; returns at q+115 when ready is back.
  task automatic lose_lock();
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(114);
  endtask

  initial begin
    bit saw_rel;

    // Lock present from the start: nominal bring-up timeline.
    pll_locked = 1'b1;
    do_reset();
    chk_reset_vals("t1_c0");
    step(15);
    chk("t1_c15 pll_resetb", 32'(pll_resetb), 0);
    step(1);
    chk("t1_c16 pll_resetb", 32'(pll_resetb), 1);
    chk("t1_c16 state", 32'(state_o), 1);
    step(64);
    chk("t1_c80 state", 32'(state_o), 2);
    step(31);
    chk("t1_c111 ready", 32'(ready), 0);
    step(1);
    chk("t1_c112 ready", 32'(ready), 1);
    chk("t1_c112 sys_reset", 32'(sys_reset), 0);
    chk("t1_c112 lost", 32'(lock_lost_count), 0);

    // One-cycle lock drop in RUN.
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    chk("t3_q2 ready", 32'(ready), 1);
    step(1);
    chk("t3_q3 ready", 32'(ready), 0);
    chk("t3_q3 sys_reset", 32'(sys_reset), 1);
    chk("t3_q3 pll_resetb", 32'(pll_resetb), 0);
    chk("t3_q3 state", 32'(state_o), 0);
    chk("t3_q3 lost", 32'(lock_lost_count), 1);
    step(111);
    chk("t3_p111 ready", 32'(ready), 0);
    step(1);
    chk("t3_p112 ready", 32'(ready), 1);

    // Many RUN losses: counter saturates at 255.
    for (int i = 0; i < 253; i++) lose_lock();
    chk("t6 lost 254", 32'(lock_lost_count), 254);
    chk("t6 ready", 32'(ready), 1);
    for (int i = 0; i < 10; i++) lose_lock();
    chk("t6 lost sat", 32'(lock_lost_count), 255);

    // Reset asserted in WAIT_LOCK.
    pll_locked = 1'b0;
    step(20);
    chk("t6 wait_lock", 32'(state_o), 1);
    reset = 1'b1;
    step(1);
    chk_reset_vals("t6_rst");
    reset = 1'b0;

    // No lock at all: four attempts then failure at cycle 16448.
    pll_locked = 1'b0;
    do_reset();
    step(16447);
    chk("t2_c16447 state", 32'(state_o), 1);
    chk("t2_c16447 fail", 32'(fail), 0);
    step(1);
    chk("t2_c16448 fail", 32'(fail), 1);
    chk("t2_c16448 state", 32'(state_o), 4);
    chk("t2_c16448 pll_resetb", 32'(pll_resetb), 0);
    step(50);
    chk("t2 fail held", 32'(fail), 1);
    chk("t2 pll_resetb held", 32'(pll_resetb), 0);

    // Restart out of failure with lock present.
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    pll_locked = 1'b1;
    chk("t5 state", 32'(state_o), 0);
    chk("t5 fail", 32'(fail), 0);
    step(111);
    chk("t5_p111 ready", 32'(ready), 0);
    step(1);
    chk("t5_p112 ready", 32'(ready), 1);

    // Lock chatter 40 high / 2 low from cycle 0: never stable, ends in failure.
    pll_locked = 1'b0;
    do_reset();
    saw_rel = 1'b0;
    for (int c = 0; c < 16448; c++) begin
      pll_locked = ((c % 42) < 40);
      step(1);
      if (state_o == 3'd2) saw_rel = 1'b1;
    end
    chk("t4 never release", 32'(saw_rel), 0);
    chk("t4 fail", 32'(fail), 1);
    chk("t4 state", 32'(state_o), 4);

    // Stable count and timeout complete on the same edge (end of cycle 4111).
    pll_locked = 1'b0;
    do_reset();
    step(4046);
    pll_locked = 1'b1;
    step(65);
    chk("t4b_c4111 state", 32'(state_o), 1);
    step(1);
    chk("t4b_c4112 state", 32'(state_o), 2);
    chk("t4b_c4112 pll_resetb", 32'(pll_resetb), 1);

    // Lock lost during RELEASE goes back to PLL reset.
    pll_locked = 1'b0;
    step(2);
    chk("t4b rel hold", 32'(state_o), 2);
    step(1);
    chk("t4b rel loss", 32'(state_o), 0);
    chk("t4b rel lost unchanged", 32'(lock_lost_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
